// File: rtl/dual_port_mem_arbiter_pkg.sv
// dual_port_mem_arbiter_pkg
// Shared constants for the dual-port memory arbiter: the arbitration FSM
// state encodings and the owner IDs used to tag which port holds the
// memory. There are no ports; the top-level arbiter imports this package.
package dual_port_mem_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_WAIT_I = 2'd1;
    localparam logic [1:0] STATE_WAIT_D = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/dual_port_mem_arbiter_req_buffer.sv
// mem_req_buffer
// One-entry request holding register that sits in front of the arbiter.
// It captures a complete request (read, write, byte enables, address and
// write data) on load_i and empties on clear_i when the request issues.
// Ports:
//   clock, reset           - system clock, async active-high reset
//   load_i                 - capture the request fields this edge
//   clear_i                - drop the held request (it has issued)
//   read_i/write_i         - request kind
//   byte_en_i/address_i/data_i - request payload
//   read_o .. data_o       - held request fields
//   full_o                 - buffer holds a request
module mem_req_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      clear_i,
    input  logic                      read_i,
    input  logic                      write_i,
    input  logic [DATA_WIDTH/8-1:0]   byte_en_i,
    input  logic [ADDRESS_BITS-1:0]   address_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic                      read_o,
    output logic                      write_o,
    output logic [DATA_WIDTH/8-1:0]   byte_en_o,
    output logic [ADDRESS_BITS-1:0]   address_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      full_o
);

    logic                    full_q;
    logic                    read_q;
    logic                    write_q;
    logic [DATA_WIDTH/8-1:0] byteEn_q;
    logic [ADDRESS_BITS-1:0] address_q;
    logic [DATA_WIDTH-1:0]   data_q;

    // Fields are zeroed on clear so an empty buffer never presents stale
    // payload to the memory-side mux.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            byteEn_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
        end else if (clear_i) begin
            full_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            byteEn_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
        end else if (load_i) begin
            full_q    <= 1'b1;
            read_q    <= read_i;
            write_q   <= write_i;
            byteEn_q  <= byte_en_i;
            address_q <= address_i;
            data_q    <= data_i;
        end
    end

    assign full_o    = full_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign byte_en_o = byteEn_q;
    assign address_o = address_q;
    assign data_o    = data_q;

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// dual_port_mem_arbiter
// Merges the instruction and data request streams from memory_interface
// onto one single-ported main memory with one transaction in flight.
// Ports:
//   clock, reset                       - system clock, async active-high reset
//   i_mem_read/i_mem_address_in        - instruction read request
//   i_mem_data_out/i_mem_address_out   - instruction response, i_mem_valid strobe
//   i_mem_ready                        - instruction buffer empty
//   d_mem_read/d_mem_write/d_mem_byte_en/d_mem_address_in/d_mem_data_in - data request
//   d_mem_data_out/d_mem_address_out   - data read response, d_mem_valid strobe
//   d_mem_ready                        - data buffer empty
//   mem_read/mem_write/mem_byte_en/mem_address_out/mem_data_out - memory request
//   mem_data_in/mem_address_in/mem_valid/mem_ready - memory response / handshake
//   scan                               - debug trace enable, no functional effect
module dual_port_mem_arbiter
    import dual_port_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_mem_read,
    input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
    output logic [DATA_WIDTH-1:0]     i_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
    output logic                      i_mem_valid,
    output logic                      i_mem_ready,
    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
    output logic [DATA_WIDTH-1:0]     d_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
    output logic                      d_mem_valid,
    output logic                      d_mem_ready,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
    output logic [ADDRESS_BITS-1:0]   mem_address_out,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [ADDRESS_BITS-1:0]   mem_address_in,
    input  logic                      mem_valid,
    input  logic                      mem_ready,
    input  logic                      scan
);

    logic [1:0] state_q, state_d;
    logic       lastGrant_q, lastGrant_d;
    logic       outWrite_q, outWrite_d;
    logic       holdValid_q, holdValid_d;
    logic       holdGrant_q, holdGrant_d;
    logic [DATA_WIDTH-1:0]   iDataOut_q, dDataOut_q;
    logic [ADDRESS_BITS-1:0] iAddrOut_q, dAddrOut_q;
    logic signed [31:0]      cycleCount_q;

    logic                    iFull, dFull, iLoad, dLoad, iClear, dClear;
    logic                    iBufRead, iBufWrite, dBufRead, dBufWrite;
    logic [DATA_WIDTH/8-1:0] iBufByteEn, dBufByteEn;
    logic [ADDRESS_BITS-1:0] iBufAddr, dBufAddr;
    logic [DATA_WIDTH-1:0]   iBufData, dBufData;

    logic grantPort, issueValid, issueFire, iResp, dResp, scanActive;

    assign i_mem_ready = !reset && !iFull;
    assign d_mem_ready = !reset && !dFull;
    assign iLoad = i_mem_ready && i_mem_read;
    assign dLoad = d_mem_ready && (d_mem_read || d_mem_write);

    mem_req_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS)) iBuffer (
        .clock(clock), .reset(reset), .load_i(iLoad), .clear_i(iClear),
        .read_i(1'b1), .write_i(1'b0), .byte_en_i('0),
        .address_i(i_mem_address_in), .data_i('0),
        .read_o(iBufRead), .write_o(iBufWrite), .byte_en_o(iBufByteEn),
        .address_o(iBufAddr), .data_o(iBufData), .full_o(iFull)
    );

    // A simultaneous read+write on the data port is illegal; it is stored as a write.
    mem_req_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS)) dBuffer (
        .clock(clock), .reset(reset), .load_i(dLoad), .clear_i(dClear),
        .read_i(d_mem_read && !d_mem_write), .write_i(d_mem_write),
        .byte_en_i(d_mem_byte_en), .address_i(d_mem_address_in), .data_i(d_mem_data_in),
        .read_o(dBufRead), .write_o(dBufWrite), .byte_en_o(dBufByteEn),
        .address_o(dBufAddr), .data_o(dBufData), .full_o(dFull)
    );

    // Once a request is presented but stalled by mem_ready=0, the grant is
    // frozen so a newly arriving request on the other port cannot swap the
    // fields under the memory's feet.
    always_comb begin
        grantPort = PORT_I;
        if (holdValid_q) begin
            grantPort = holdGrant_q;
        end else if (iFull && dFull) begin
            grantPort = (lastGrant_q == PORT_I) ? PORT_D : PORT_I;
        end else if (dFull) begin
            grantPort = PORT_D;
        end
    end

    assign issueValid = (state_q == STATE_IDLE) && (iFull || dFull);
    assign issueFire  = issueValid && mem_ready;
    assign iClear     = issueFire && (grantPort == PORT_I);
    assign dClear     = issueFire && (grantPort == PORT_D);

    assign mem_read        = issueValid && ((grantPort == PORT_D) ? dBufRead : iBufRead);
    assign mem_write       = issueValid && ((grantPort == PORT_D) ? dBufWrite : iBufWrite);
    assign mem_byte_en     = !issueValid ? '0 : ((grantPort == PORT_D) ? dBufByteEn : iBufByteEn);
    assign mem_address_out = !issueValid ? '0 : ((grantPort == PORT_D) ? dBufAddr : iBufAddr);
    assign mem_data_out    = !issueValid ? '0 : ((grantPort == PORT_D) ? dBufData : iBufData);

    // Responses only count while a transaction is outstanding, so stray
    // mem_valid pulses in IDLE (including after a reset) are ignored.
    assign iResp = mem_valid && (state_q == STATE_WAIT_I);
    assign dResp = mem_valid && (state_q == STATE_WAIT_D);

    assign i_mem_valid       = iResp;
    assign d_mem_valid       = dResp && !outWrite_q;
    assign i_mem_data_out    = iResp ? mem_data_in : iDataOut_q;
    assign i_mem_address_out = iResp ? mem_address_in : iAddrOut_q;
    assign d_mem_data_out    = dResp ? mem_data_in : dDataOut_q;
    assign d_mem_address_out = dResp ? mem_address_in : dAddrOut_q;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = issueFire ? grantPort : lastGrant_q;
        outWrite_d  = issueFire ? mem_write : outWrite_q;
        holdValid_d = issueValid && !mem_ready;
        holdGrant_d = grantPort;
        case (state_q)
            STATE_IDLE: begin
                if (issueFire) begin
                    state_d = (grantPort == PORT_D) ? STATE_WAIT_D : STATE_WAIT_I;
                end
            end
            STATE_WAIT_I, STATE_WAIT_D: begin
                if (mem_valid) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // Response registers keep the last value seen by each port so the
    // non-owning port's data_out does not move.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= STATE_IDLE;
            lastGrant_q  <= PORT_I;
            outWrite_q   <= 1'b0;
            holdValid_q  <= 1'b0;
            holdGrant_q  <= PORT_I;
            iDataOut_q   <= '0;
            iAddrOut_q   <= '0;
            dDataOut_q   <= '0;
            dAddrOut_q   <= '0;
            cycleCount_q <= '0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            outWrite_q   <= outWrite_d;
            holdValid_q  <= holdValid_d;
            holdGrant_q  <= holdGrant_d;
            cycleCount_q <= cycleCount_q + 32'sd1;
            if (iResp) begin
                iDataOut_q <= mem_data_in;
                iAddrOut_q <= mem_address_in;
            end
            if (dResp) begin
                dDataOut_q <= mem_data_in;
                dAddrOut_q <= mem_address_in;
            end
        end
    end

    // The trace window is kept for debug builds; it drives nothing here.
    assign scanActive = scan && (cycleCount_q >= SCAN_CYCLES_MIN) &&
                        (cycleCount_q <= SCAN_CYCLES_MAX);

    logic unusedScan;
    assign unusedScan = scanActive;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// tb_dual_port_mem_arbiter
// Directed self-checking bench for dual_port_mem_arbiter. Each task drives
// one scenario cycle by cycle and compares outputs against hand-computed
// values, sampling a few time units after the rising edge.
module tb_dual_port_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_mem_read;
    logic [31:0] i_mem_address_in;
    logic [31:0] i_mem_data_out, i_mem_address_out;
    logic        i_mem_valid, i_mem_ready;
    logic        d_mem_read, d_mem_write;
    logic [3:0]  d_mem_byte_en;
    logic [31:0] d_mem_address_in, d_mem_data_in;
    logic [31:0] d_mem_data_out, d_mem_address_out;
    logic        d_mem_valid, d_mem_ready;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_address_out, mem_data_out;
    logic [31:0] mem_data_in, mem_address_in;
    logic        mem_valid, mem_ready;
    logic        scan;

    int checks = 0;
    int errors = 0;

    dual_port_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
        .i_mem_data_out(i_mem_data_out), .i_mem_address_out(i_mem_address_out),
        .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
        .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
        .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
        .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
        .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_address_in(mem_address_in),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .scan(scan)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge; inputs set here are seen
    // at the following edge and combinational outputs settle before sampling.
    task automatic nextCycle();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_mem_read = 0; i_mem_address_in = 0;
        d_mem_read = 0; d_mem_write = 0; d_mem_byte_en = 0; d_mem_address_in = 0; d_mem_data_in = 0;
        mem_data_in = 0; mem_address_in = 0; mem_valid = 0; mem_ready = 1; scan = 0;
        repeat (2) @(posedge clock);
        #2;
        checks++; if (i_mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_i_ready got %0b want 0", i_mem_ready); end
        checks++; if (d_mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_d_ready got %0b want 0", d_mem_ready); end
        checks++; if ({mem_read, mem_write, i_mem_valid, d_mem_valid} !== 4'b0) begin errors++; $display("[TB] FAIL rst_strobes got %b want 0000", {mem_read, mem_write, i_mem_valid, d_mem_valid}); end
        checks++; if ({i_mem_data_out, d_mem_data_out, mem_address_out} !== 96'h0) begin errors++; $display("[TB] FAIL rst_buses got %h want 0", {i_mem_data_out, d_mem_data_out, mem_address_out}); end
        reset = 1'b0;
        #1;
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b11) begin errors++; $display("[TB] FAIL rel_ready got %b want 11", {i_mem_ready, d_mem_ready}); end
        // Stall a request, then assert reset mid-cycle.
        nextCycle(); i_mem_read = 1; i_mem_address_in = 32'h4; mem_ready = 0;
        nextCycle(); i_mem_read = 0; #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_mem_read got %0b want 1", mem_read); end
        reset = 1'b1; #1;
        checks++; if ({mem_read, mem_write, i_mem_ready, d_mem_ready, i_mem_valid, d_mem_valid} !== 6'b0) begin errors++; $display("[TB] FAIL mid_rst_outputs got %b want 000000", {mem_read, mem_write, i_mem_ready, d_mem_ready, i_mem_valid, d_mem_valid}); end
        checks++; if (mem_address_out !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_addr got %h want 0", mem_address_out); end
        nextCycle(); reset = 1'b0; mem_ready = 1; #1;
        checks++; if ({i_mem_ready, d_mem_ready, mem_read} !== 3'b110) begin errors++; $display("[TB] FAIL post_rst got %b want 110", {i_mem_ready, d_mem_ready, mem_read}); end
    endtask

    task automatic test_instr_read();
        nextCycle(); i_mem_read = 1; i_mem_address_in = 32'h10; #1;
        checks++; if (i_mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL ir_ready0 got %0b want 1", i_mem_ready); end
        nextCycle(); i_mem_read = 0; #1;
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("[TB] FAIL ir_cmd got %b want 10", {mem_read, mem_write}); end
        checks++; if (mem_address_out !== 32'h10) begin errors++; $display("[TB] FAIL ir_addr got %h want 10", mem_address_out); end
        checks++; if (i_mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL ir_ready1 got %0b want 0", i_mem_ready); end
        nextCycle(); mem_valid = 1; mem_data_in = 32'hDEADBEEF; mem_address_in = 32'h10; #1;
        checks++; if ({i_mem_valid, d_mem_valid, mem_read} !== 3'b100) begin errors++; $display("[TB] FAIL ir_valid got %b want 100", {i_mem_valid, d_mem_valid, mem_read}); end
        checks++; if (i_mem_data_out !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ir_data got %h want deadbeef", i_mem_data_out); end
        checks++; if (i_mem_address_out !== 32'h10) begin errors++; $display("[TB] FAIL ir_raddr got %h want 10", i_mem_address_out); end
        checks++; if (d_mem_data_out !== 32'h0) begin errors++; $display("[TB] FAIL ir_d_hold got %h want 0", d_mem_data_out); end
        nextCycle(); mem_valid = 0; mem_data_in = 0; #1;
        checks++; if (i_mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL ir_valid_drop got %0b want 0", i_mem_valid); end
        checks++; if (i_mem_data_out !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ir_data_hold got %h want deadbeef", i_mem_data_out); end
    endtask

    // Simultaneous I read 0x20 and D read 0x100; dFirst is the expected winner.
    task automatic test_conflict(input logic dFirst, input logic [31:0] salt);
        logic [31:0] firstAddr, secondAddr, firstData, secondData, obsData;
        firstAddr  = dFirst ? 32'h100 : 32'h20;
        secondAddr = dFirst ? 32'h20 : 32'h100;
        firstData  = 32'hA0000000 ^ salt ^ firstAddr;
        secondData = 32'hB0000000 ^ salt ^ secondAddr;
        nextCycle(); i_mem_read = 1; i_mem_address_in = 32'h20; d_mem_read = 1; d_mem_address_in = 32'h100;
        nextCycle(); i_mem_read = 0; d_mem_read = 0; #1;
        checks++; if (mem_read !== 1'b1 || mem_address_out !== firstAddr) begin errors++; $display("[TB] FAIL cf_first_issue got rd=%0b addr=%h want rd=1 addr=%h", mem_read, mem_address_out, firstAddr); end
        nextCycle(); mem_valid = 1; mem_data_in = firstData; mem_address_in = firstAddr; #1;
        checks++; if ({i_mem_valid, d_mem_valid} !== {!dFirst, dFirst}) begin errors++; $display("[TB] FAIL cf_first_valid got %b want %b", {i_mem_valid, d_mem_valid}, {!dFirst, dFirst}); end
        obsData = dFirst ? d_mem_data_out : i_mem_data_out;
        checks++; if (obsData !== firstData) begin errors++; $display("[TB] FAIL cf_first_data got %h want %h", obsData, firstData); end
        nextCycle(); mem_valid = 0; #1;
        checks++; if (mem_read !== 1'b1 || mem_address_out !== secondAddr) begin errors++; $display("[TB] FAIL cf_second_issue got rd=%0b addr=%h want rd=1 addr=%h", mem_read, mem_address_out, secondAddr); end
        nextCycle(); mem_valid = 1; mem_data_in = secondData; mem_address_in = secondAddr; #1;
        checks++; if ({i_mem_valid, d_mem_valid} !== {dFirst, !dFirst}) begin errors++; $display("[TB] FAIL cf_second_valid got %b want %b", {i_mem_valid, d_mem_valid}, {dFirst, !dFirst}); end
        obsData = dFirst ? i_mem_data_out : d_mem_data_out;
        checks++; if (obsData !== secondData) begin errors++; $display("[TB] FAIL cf_second_data got %h want %h", obsData, secondData); end
        nextCycle(); mem_valid = 0;
    endtask

    task automatic test_write(input logic alsoRead, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        nextCycle(); d_mem_write = 1; d_mem_read = alsoRead; d_mem_address_in = addr; d_mem_data_in = data; d_mem_byte_en = be;
        nextCycle(); d_mem_write = 0; d_mem_read = 0; d_mem_data_in = 0; d_mem_byte_en = 0; #1;
        checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("[TB] FAIL wr_cmd got %b want 01", {mem_read, mem_write}); end
        checks++; if (mem_address_out !== addr || mem_data_out !== data || mem_byte_en !== be) begin errors++; $display("[TB] FAIL wr_fields got %h/%h/%b want %h/%h/%b", mem_address_out, mem_data_out, mem_byte_en, addr, data, be); end
        nextCycle(); mem_valid = 1; mem_data_in = 32'h0; mem_address_in = addr; #1;
        checks++; if ({d_mem_valid, i_mem_valid, mem_write} !== 3'b000) begin errors++; $display("[TB] FAIL wr_ack got %b want 000", {d_mem_valid, i_mem_valid, mem_write}); end
        nextCycle(); mem_valid = 0; #1;
        checks++; if ({d_mem_ready, mem_write, d_mem_valid} !== 3'b100) begin errors++; $display("[TB] FAIL wr_idle got %b want 100", {d_mem_ready, mem_write, d_mem_valid}); end
    endtask

    task automatic test_backpressure();
        nextCycle(); i_mem_read = 1; i_mem_address_in = 32'h80; mem_ready = 0;
        nextCycle(); i_mem_read = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) nextCycle();
            #1;
            checks++; if (mem_read !== 1'b1 || mem_address_out !== 32'h80 || i_mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d got rd=%0b addr=%h rdy=%0b want rd=1 addr=80 rdy=0", c, mem_read, mem_address_out, i_mem_ready); end
        end
        nextCycle(); mem_ready = 1; #1;
        checks++; if (mem_read !== 1'b1 || mem_address_out !== 32'h80 || i_mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_issue got rd=%0b addr=%h rdy=%0b want rd=1 addr=80 rdy=0", mem_read, mem_address_out, i_mem_ready); end
        nextCycle(); mem_valid = 1; mem_data_in = 32'h0BADF00D; mem_address_in = 32'h80; #1;
        checks++; if (i_mem_valid !== 1'b1 || i_mem_data_out !== 32'h0BADF00D || i_mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_resp got v=%0b data=%h rdy=%0b want v=1 data=0badf00d rdy=1", i_mem_valid, i_mem_data_out, i_mem_ready); end
        nextCycle(); mem_valid = 0;
    endtask

    task automatic test_spurious_valid();
        nextCycle(); mem_valid = 1; mem_data_in = 32'h55555555; mem_address_in = 32'h999; #1;
        checks++; if ({i_mem_valid, d_mem_valid, mem_read} !== 3'b000) begin errors++; $display("[TB] FAIL spur_valid got %b want 000", {i_mem_valid, d_mem_valid, mem_read}); end
        checks++; if (i_mem_data_out !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL spur_data got %h want 0badf00d", i_mem_data_out); end
        nextCycle(); mem_valid = 0;
    endtask

    task automatic test_reset_mid_wait();
        nextCycle(); d_mem_read = 1; d_mem_address_in = 32'h200;
        nextCycle(); d_mem_read = 0; #1;
        checks++; if (mem_read !== 1'b1 || mem_address_out !== 32'h200) begin errors++; $display("[TB] FAIL rw_issue got rd=%0b addr=%h want rd=1 addr=200", mem_read, mem_address_out); end
        nextCycle(); reset = 1; #1;
        checks++; if ({d_mem_valid, d_mem_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rw_in_rst got %b want 00", {d_mem_valid, d_mem_ready}); end
        nextCycle(); reset = 0; mem_valid = 1; mem_data_in = 32'h77777777; mem_address_in = 32'h200; #1;
        checks++; if ({d_mem_valid, mem_read, d_mem_ready} !== 3'b001) begin errors++; $display("[TB] FAIL rw_late_valid got %b want 001", {d_mem_valid, mem_read, d_mem_ready}); end
        nextCycle(); mem_valid = 0; i_mem_read = 1; i_mem_address_in = 32'h300; #1;
        checks++; if (d_mem_data_out !== 32'h0) begin errors++; $display("[TB] FAIL rw_d_data got %h want 0", d_mem_data_out); end
        nextCycle(); i_mem_read = 0; #1;
        checks++; if (mem_read !== 1'b1 || mem_address_out !== 32'h300) begin errors++; $display("[TB] FAIL rw_idle_issue got rd=%0b addr=%h want rd=1 addr=300", mem_read, mem_address_out); end
        nextCycle(); mem_valid = 1; mem_data_in = 32'h31313131; mem_address_in = 32'h300; #1;
        checks++; if (i_mem_valid !== 1'b1 || i_mem_data_out !== 32'h31313131) begin errors++; $display("[TB] FAIL rw_final got v=%0b data=%h want v=1 data=31313131", i_mem_valid, i_mem_data_out); end
        nextCycle(); mem_valid = 0;
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_conflict(1'b1, 32'h1);
        test_write(1'b0, 32'h40, 32'h12345678, 4'b0011);
        test_write(1'b1, 32'h44, 32'hCAFEF00D, 4'b1111);
        test_conflict(1'b0, 32'h2);
        test_backpressure();
        test_spurious_valid();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_arbiter.md
Name:
dual_port_mem_arbiter

Overview:
- Sits downstream of the memory_interface block; merges its instruction (i_mem_*) and data (d_mem_*) request streams onto one single-ported main memory (mem_*).
- Lets five-stage cores run on unified, multi-cycle memories.
- Each port gets a one-entry request buffer, an arbitration FSM, and response routing back to the owning port.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDRESS_BITS, 32, address width.
- SCAN_CYCLES_MIN, 0, first cycle of scan debug display.
- SCAN_CYCLES_MAX, 1000, last cycle of scan debug display.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- i_mem_read  input  1  instruction read request.
- i_mem_address_in  input  ADDRESS_BITS  instruction request address.
- i_mem_data_out / i_mem_address_out  output  DATA_WIDTH / ADDRESS_BITS  instruction response data and its address.
- i_mem_valid  output  1  instruction response valid.
- i_mem_ready  output  1  instruction port can accept a request.
- d_mem_read / d_mem_write  input  1 / 1  data read / write request.
- d_mem_byte_en  input  DATA_WIDTH/8  write byte enables.
- d_mem_address_in / d_mem_data_in  input  ADDRESS_BITS / DATA_WIDTH  data request address and write data.
- d_mem_data_out / d_mem_address_out  output  DATA_WIDTH / ADDRESS_BITS  data read response and its address.
- d_mem_valid  output  1  data read response valid.
- d_mem_ready  output  1  data port can accept a request.
- mem_read / mem_write  output  1 / 1  request to main memory.
- mem_byte_en  output  DATA_WIDTH/8  byte enables to memory.
- mem_address_out / mem_data_out  output  ADDRESS_BITS / DATA_WIDTH  request address and write data to memory.
- mem_data_in / mem_address_in  input  DATA_WIDTH / ADDRESS_BITS  memory response data and address.
- mem_valid  input  1  memory response valid; also acknowledges writes.
- mem_ready  input  1  memory accepts a request this cycle.
- scan  input  1  enables $display trace inside the SCAN window; no functional effect.

Behaviour:
- Clock and reset: one clock, named clock; reset is asynchronous and active-high, named reset.
- Reset state: both buffers empty, FSM IDLE, last_grant=I, cycle counter=0.
  - While reset is high, all valid, ready, mem_read and mem_write outputs are 0.
  - Data and address outputs are 0 while reset is high.
- Port ready:
  - i_mem_ready = !reset && i_buf empty.
  - d_mem_ready = !reset && d_buf empty.
- Buffer capture: at the clock edge, a buffer loads when its port is ready and a request is present.
  - I port request: i_mem_read.
  - D port request: d_mem_read|d_mem_write.
  - d_mem_read && d_mem_write together is illegal; treat it as a write.
- FSM: IDLE, WAIT_I, WAIT_D.
- Issue from IDLE: requires at least one buffer full.
  - Drive mem_* combinationally from the granted buffer.
  - When mem_ready=1: clear that buffer, set last_grant, and go to WAIT_I or WAIT_D.
  - When mem_ready=0: hold all mem_* signals stable and stay IDLE.
- Grant on conflict (both buffers full): grant the port opposite to last_grant. After reset the first conflict therefore goes to D.
- Completion in WAIT_x: on mem_valid=1, route the response to the owning port.
  - x_mem_data_out = mem_data_in and x_mem_address_out = mem_address_in, combinationally.
  - Read: x_mem_valid=1 for that cycle only.
  - Write: ack only, d_mem_valid stays 0.
  - Return to IDLE; the next issue occurs in the following cycle at the earliest.
- Latency, memory with 1-cycle response: request accepted in cycle T → mem request in T+1 → response and port valid in T+2.
- Spurious mem_valid in IDLE: ignored, no port valid.
- Reset during WAIT_x: outstanding transaction is dropped; a late mem_valid after reset is ignored.
- Non-owner port: its valid stays 0 and its data_out holds its last value.
- Exactly one outstanding memory transaction at a time.

Decomposition:
- Shared package (localparam include): FSM state encodings IDLE/WAIT_I/WAIT_D; owner IDs PORT_I/PORT_D.
- Sub-module mem_req_buffer: one-entry holding register carrying read, write, byte_en, address, data, full; clear-on-issue. Instantiated twice.

Test Plan:
- Reset:
  - Assert reset mid-cycle → i_mem_ready, d_mem_ready, mem_read, mem_write and all valids go 0 immediately.
  - After release, both ready signals are 1.
- Instruction read:
  - Stimulus: i_mem_read at 0x10 in cycle 0; memory returns 0xDEADBEEF with 1-cycle latency.
  - Response: mem_read=1 at address 0x10 in cycle 1; i_mem_valid=1 with data 0xDEADBEEF in cycle 2; d_mem_valid stays 0.
- Conflict fairness:
  - Stimulus: I 0x20 and D read 0x100 issued simultaneously, twice in succession.
  - Response: first pair is serviced D then I; second pair is serviced I then D.
- Write:
  - Stimulus: d_mem_write to 0x40, data 0x12345678, byte_en 4'b0011.
  - Response: memory sees identical fields; the ack produces d_mem_valid=0 and the FSM returns to IDLE.
- Backpressure:
  - Stimulus: mem_ready=0 for 3 cycles with a request pending.
  - Response: mem_* held stable, port ready stays 0; issue happens on the cycle mem_ready=1.
- Reset mid-wait:
  - Stimulus: reset in WAIT_D, then mem_valid after release.
  - Response: no d_mem_valid; FSM stays IDLE.
